led_afterglow: RTL and testbench



---
 rtl/led_afterglow.sv | 102 ++++++++++
 tb/tb_led_afterglow.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/led_afterglow.sv
// PWM afterglow stage between the LED pattern counter and the board LED pins.
// Lit pattern bits drive LEDs fully on; released bits fade out at a fixed decay rate (GAMMA_EN: squared-level duty).
module led_afterglow #(
    parameter int N_LED        = 8,
    parameter int PWM_BITS     = 8,
    parameter int DECAY_PERIOD = 65536,
    parameter int DECAY_STEP   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_LED-1:0] pattern_in,
    output logic [N_LED-1:0] led_out,
    output logic             pwm_frame
);

    localparam int                TMR_W    = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(DECAY_PERIOD - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

    logic [TMR_W-1:0]    decay_tmr;
    logic                decay_tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_end;
    logic [PWM_BITS-1:0] level     [N_LED];
    logic [PWM_BITS-1:0] duty      [N_LED];
    logic [PWM_BITS-1:0] duty_next [N_LED];

    // Down-counter reloaded at terminal count; ticks every DECAY_PERIOD cycles from release.
    assign decay_tick = (decay_tmr == '0);
    assign frame_end  = (pwm_cnt == LVL_MAX);
    assign pwm_frame  = frame_end;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            decay_tmr <= TMR_LOAD;
        end else if (decay_tick) begin
            decay_tmr <= TMR_LOAD;
        end else begin
            decay_tmr <= decay_tmr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_duty_map
`ifdef GAMMA_EN
        logic [2*PWM_BITS-1:0] level_sq;
        assign level_sq     = {{PWM_BITS{1'b0}}, level[g]} * {{PWM_BITS{1'b0}}, level[g]};
        assign duty_next[g] = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
        assign duty_next[g] = level[g];
`endif
    end

    // A fresh pattern bit beats a decay tick landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LED; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                if (pattern_in[i]) begin
                    level[i] <= LVL_MAX;
                end else if (decay_tick) begin
                    level[i] <= (level[i] > STEP) ? (level[i] - STEP) : '0;
                end
            end
        end
    end

    // Duty is shadowed so a frame never changes its compare value mid-period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LED; i++) begin
                duty[i] <= '0;
            end
        end else if (frame_end) begin
            for (int i = 0; i < N_LED; i++) begin
                duty[i] <= duty_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_out <= '0;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                led_out[i] <= pattern_in[i] | (pwm_cnt < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_afterglow.sv
// Bench for led_afterglow: directed fade/saturation/priority/reset steps, then random patterns,
// all checked cycle by cycle against an arithmetic model of levels, duties and frame position.
module tb_led_afterglow;

    localparam int NL   = 8;
    localparam int PB   = 4;
    localparam int DP   = 8;
    localparam int DS   = 4;
    localparam int LMAX = (1 << PB) - 1;
    localparam int FR   = 1 << PB;

`ifdef GAMMA_EN
    localparam int E_FULL = 14;
    localparam int E_11   = 7;
    localparam int E_3    = 0;
`else
    localparam int E_FULL = 15;
    localparam int E_11   = 11;
    localparam int E_3    = 3;
`endif

    logic          clk;
    logic          reset_n;
    logic [NL-1:0] pattern_in;
    logic [NL-1:0] led_out;
    logic          pwm_frame;

    int n_checks = 0;
    int n_pass   = 0;

    // model: edges since the last reset edge, per-LED level and shadow duty
    int   m_n;
    int   m_lvl  [NL];
    int   m_duty [NL];
    logic [NL-1:0] m_led;

    led_afterglow #(
        .N_LED       (NL),
        .PWM_BITS    (PB),
        .DECAY_PERIOD(DP),
        .DECAY_STEP  (DS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pattern_in(pattern_in),
        .led_out   (led_out),
        .pwm_frame (pwm_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int f_duty(input int lvl);
`ifdef GAMMA_EN
        return (lvl * lvl) >> PB;
`else
        return lvl;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic [NL-1:0] pat, input logic rst_n);
        int pos;
        bit tick;
        @(negedge clk);
        pattern_in = pat;
        reset_n    = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            m_n   = 0;
            m_led = '0;
            for (int i = 0; i < NL; i++) begin
                m_lvl[i]  = 0;
                m_duty[i] = 0;
            end
        end else begin
            pos  = m_n % FR;
            tick = (m_n % DP) == DP - 1;
            for (int i = 0; i < NL; i++) begin
                m_led[i] = pat[i] || (pos < m_duty[i]);
                if (pos == FR - 1) m_duty[i] = f_duty(m_lvl[i]);
                if (pat[i])        m_lvl[i] = LMAX;
                else if (tick)     m_lvl[i] = (m_lvl[i] > DS) ? m_lvl[i] - DS : 0;
            end
            m_n++;
        end
        #1;
        check("led_out", int'(led_out), int'(m_led));
        check("pwm_frame", int'(pwm_frame), int'(rst_n && (m_n % FR) == FR - 1));
    endtask

    task automatic frame_count(input logic [NL-1:0] pat, input int bitn, output int cnt);
        cnt = 0;
        for (int k = 0; k < FR; k++) begin
            step(pat, 1'b1);
            cnt += int'(led_out[bitn]);
        end
    endtask

    initial begin
        int cnt;
        logic [NL-1:0] rp;
        logic rr;
        reset_n    = 1'b0;
        pattern_in = 8'hFF;
        m_n        = 0;
        m_led      = '0;
        for (int i = 0; i < NL; i++) begin
            m_lvl[i]  = 0;
            m_duty[i] = 0;
        end

        // reset held with pattern asserted, then release
        repeat (3) step(8'hFF, 1'b0);
        step(8'hFF, 1'b1);
        check("release_led", int'(led_out), 'hFF);

        // fade of LED0 through linear steps into saturation
        repeat (15) step(8'h01, 1'b1);
        frame_count(8'h00, 0, cnt);
        check("fade_full", cnt, E_FULL);
        frame_count(8'h00, 0, cnt);
        check("fade_11", cnt, E_11);
        frame_count(8'h00, 0, cnt);
        check("fade_3", cnt, E_3);
        frame_count(8'h00, 0, cnt);
        check("sat_zero_a", cnt, 0);
        frame_count(8'h00, 0, cnt);
        check("sat_zero_b", cnt, 0);

        // pattern bit 2 coinciding with a decay tick while level is 7
        step(8'h04, 1'b1);
        repeat (22) step(8'h00, 1'b1);
        step(8'h04, 1'b1);
        check("simul_led2", int'(led_out[2]), 1);
        repeat (8) step(8'h00, 1'b1);
        frame_count(8'h00, 2, cnt);
        check("simul_level", cnt, E_FULL);

        // reset pulse while LED0 level is 11
        step(8'h01, 1'b1);
        repeat (8) step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        check("midreset_led", int'(led_out), 0);
        frame_count(8'h00, 0, cnt);
        check("midreset_dark_a", cnt, 0);
        frame_count(8'h00, 0, cnt);
        check("midreset_dark_b", cnt, 0);

        // random sparse patterns with occasional resets
        for (int k = 0; k < 800; k++) begin
            rp = NL'($urandom) & NL'($urandom) & NL'($urandom);
            rr = ($urandom_range(0, 99) != 0);
            step(rp, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
